// File: rtl/axi_lite_arb_pkg.sv
// Shared types and defaults for the AXI4-Lite requester arbiter.
//   arb_state_e : sequencing states of the arbiter FSM
//   ARB_ADDR_W  : default requester/master address width
//   ARB_DATA_W  : default data width
package axi_lite_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/axi_arb_rr_pick.sv
// Combinational rotating-priority encoder for round-robin arbitration.
// Scans last+1, last+2, ... (mod NUM_REQ) and reports the first set request.
// Ports:
//   req   in  [NUM_REQ]          request vector
//   last  in  [$clog2(NUM_REQ)]  index granted most recently
//   valid out                    at least one request is set
//   idx   out [$clog2(NUM_REQ)]  winning requester index
module axi_arb_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic                       valid,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] pos;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = '0;
        // Walk from the farthest slot back toward last+1 so the nearest
        // requester after last is the one left standing.
        for (int off = NUM_REQ; off >= 1; off--) begin
            pos = IDX_W'((int'(last) + off) % NUM_REQ);
            if (req[pos]) begin
                valid = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/axi_lite_req_arbiter.sv
// Shares one AXI4-Lite master internal port between NUM_REQ requesters.
// Round-robin arbitration, one outstanding transaction at a time. The winning
// command is latched in IDLE, presented to the master with a one-cycle
// transfer pulse, held until ready, and completed with a one-cycle ack.
//
// Optional feature: define AXI_ARB_LOCK_EN to add req_lock, which lets the
// last granted requester keep the bus while it holds both req and req_lock.
//
// Ports:
//   ACLK, ARESET         clock, synchronous active-high reset
//   req/req_write        per-requester request and direction (1=write)
//   req_addr/req_wdata   packed payloads, requester i at [i*W +: W]
//   req_lock             (AXI_ARB_LOCK_EN only) per-requester lock request
//   ack/ack_rdata        one-cycle completion pulse and read data
//   grant_idx            current/last granted requester
//   busy                 high from grant through the ack cycle
//   transfer/ready       master start pulse / completion pulse
//   addr/wdata/write     master command, stable from transfer until ready
//   rdata                master read data, valid with ready
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no transaction; arbitrate and latch the winner's command
// ISSUE | transfer pulse to the master
// WAIT  | command held; waiting for ready
// RESP  | ack pulse to the granted requester; rr pointer updated
module axi_lite_req_arbiter
    import axi_lite_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = ARB_ADDR_W,
    parameter int DATA_W  = ARB_DATA_W
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
`ifdef AXI_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]         req_lock,
`endif
    output logic [NUM_REQ-1:0]         ack,
    output logic [DATA_W-1:0]          ack_rdata,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       busy,
    output logic                       transfer,
    input  logic                       ready,
    output logic [ADDR_W-1:0]          addr,
    output logic [DATA_W-1:0]          wdata,
    output logic                       write,
    input  logic [DATA_W-1:0]          rdata
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               write_q, write_d;
    logic               busy_q, busy_d;
    logic               transfer_q, transfer_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [DATA_W-1:0]  ack_rdata_q, ack_rdata_d;
`ifdef AXI_ARB_LOCK_EN
    logic               lock_q, lock_d;
`endif

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic               grant_ok;
    logic [IDX_W-1:0]   sel_idx;

    axi_arb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req   (req),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        gidx_d      = gidx_q;
        last_d      = last_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        busy_d      = busy_q;
        transfer_d  = 1'b0;
        ack_d       = '0;
        ack_rdata_d = ack_rdata_q;
        grant_ok    = 1'b0;
        sel_idx     = pick_idx;
`ifdef AXI_ARB_LOCK_EN
        lock_d      = lock_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef AXI_ARB_LOCK_EN
                // A held lock re-grants the previous owner ahead of round-robin;
                // dropping either req or req_lock hands the bus back to rr.
                if (lock_q && req[gidx_q] && req_lock[gidx_q]) begin
                    sel_idx  = gidx_q;
                    grant_ok = 1'b1;
                end else begin
                    grant_ok = pick_valid;
                end
                lock_d = 1'b0;
`else
                grant_ok = pick_valid;
`endif
                if (grant_ok) begin
                    gidx_d     = sel_idx;
                    busy_d     = 1'b1;
                    transfer_d = 1'b1;
                    state_d    = ISSUE;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (sel_idx == IDX_W'(i)) begin
                            addr_d  = req_addr[i*ADDR_W +: ADDR_W];
                            wdata_d = req_wdata[i*DATA_W +: DATA_W];
                            write_d = req_write[i];
                        end
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (ready) begin
                    ack_rdata_d    = write_q ? '0 : rdata;
                    ack_d[gidx_q]  = 1'b1;
                    state_d        = RESP;
                end
            end
            RESP: begin
                // Re-granting the same index under lock leaves last unchanged,
                // so the rr pointer does not move while the lock is held.
                last_d  = gidx_q;
                busy_d  = 1'b0;
                state_d = IDLE;
`ifdef AXI_ARB_LOCK_EN
                lock_d  = req_lock[gidx_q];
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= IDLE;
            gidx_q      <= '0;
            last_q      <= IDX_W'(NUM_REQ - 1);
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            busy_q      <= 1'b0;
            transfer_q  <= 1'b0;
            ack_q       <= '0;
            ack_rdata_q <= '0;
`ifdef AXI_ARB_LOCK_EN
            lock_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gidx_q      <= gidx_d;
            last_q      <= last_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            busy_q      <= busy_d;
            transfer_q  <= transfer_d;
            ack_q       <= ack_d;
            ack_rdata_q <= ack_rdata_d;
`ifdef AXI_ARB_LOCK_EN
            lock_q      <= lock_d;
`endif
        end
    end

    assign ack       = ack_q;
    assign ack_rdata = ack_rdata_q;
    assign grant_idx = gidx_q;
    assign busy      = busy_q;
    assign transfer  = transfer_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign write     = write_q;

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// Bench for axi_lite_req_arbiter: directed scenarios with literal
// expectations, then randomized requesters/master/reset, all checked every
// cycle against a transaction-level reference model.
module tb_axi_lite_req_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 2;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic [NR-1:0]     req;
    logic [NR-1:0]     req_write;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     ack;
    logic [DW-1:0]     ack_rdata;
    logic [IW-1:0]     grant_idx;
    logic              busy;
    logic              transfer;
    logic              ready;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wdata;
    logic              write;
    logic [DW-1:0]     rdata;
`ifdef AXI_ARB_LOCK_EN
    logic [NR-1:0]     req_lock = '0;
`endif

    int          n_total = 0;
    int          n_bad   = 0;
    logic        mst_rand = 1'b0;
    logic        mst_hold = 1'b0;
    logic [31:0] dir_rdata = 32'h0;

    // reference model: expected registered outputs after each edge
    logic          m_valid = 1'b0;
    logic          m_busy, m_tx, m_wr;
    logic [NR-1:0] m_ack;
    logic [DW-1:0] m_rd, m_wdata;
    logic [AW-1:0] m_addr;
    logic [IW-1:0] m_gidx;
    int            m_last;

    always #5 ACLK = ~ACLK;

    axi_lite_req_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (ack),
        .ack_rdata (ack_rdata),
        .grant_idx (grant_idx),
        .busy      (busy),
        .transfer  (transfer),
        .ready     (ready),
        .addr      (addr),
        .wdata     (wdata),
        .write     (write),
        .rdata     (rdata)
`ifdef AXI_ARB_LOCK_EN
        , .req_lock (req_lock)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: a grant opens a transaction, the master sees
    // one transfer cycle, the first ready after that produces an ack, and the
    // cycle after the ack the bus is free again. Winner is the requester at
    // the smallest circular distance after the previous winner.
    initial begin
        int best;
        int bd;
        int d;
        forever begin
            @(posedge ACLK);
            if (ARESET) begin
                m_busy = 1'b0; m_tx = 1'b0; m_wr = 1'b0; m_ack = '0;
                m_rd = '0; m_wdata = '0; m_addr = '0; m_gidx = '0;
                m_last = NR - 1; m_valid = 1'b1;
            end else if (m_ack != '0) begin
                m_ack  = '0;
                m_busy = 1'b0;
                m_last = int'(m_gidx);
            end else if (!m_busy) begin
                best = -1;
                bd   = NR;
                for (int i = 0; i < NR; i++) begin
                    d = (i - m_last - 1 + 2 * NR) % NR;
                    if (req[i] && d < bd) begin
                        bd   = d;
                        best = i;
                    end
                end
                if (best >= 0) begin
                    m_busy  = 1'b1;
                    m_tx    = 1'b1;
                    m_gidx  = IW'(best);
                    m_addr  = req_addr[best*AW +: AW];
                    m_wdata = req_wdata[best*DW +: DW];
                    m_wr    = req_write[best];
                end
            end else if (m_tx) begin
                m_tx = 1'b0;
            end else if (ready) begin
                m_rd           = m_wr ? '0 : rdata;
                m_ack[m_gidx]  = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge ACLK);
            if (m_valid) begin
                chk("m_busy",      64'(busy),      64'(m_busy));
                chk("m_transfer",  64'(transfer),  64'(m_tx));
                chk("m_ack",       64'(ack),       64'(m_ack));
                chk("m_ack_rdata", 64'(ack_rdata), 64'(m_rd));
                chk("m_grant_idx", 64'(grant_idx), 64'(m_gidx));
                chk("m_addr",      64'(addr),      64'(m_addr));
                chk("m_wdata",     64'(wdata),     64'(m_wdata));
                chk("m_write",     64'(write),     64'(m_wr));
            end
        end
    end

    // One cycle: land on the falling edge, then update the master response.
    task automatic step();
        @(negedge ACLK);
        if (mst_rand) begin
            ready = ($urandom_range(0, 2) == 0);
            rdata = $urandom;
        end else begin
            ready = busy && !transfer && (ack == '0) && !mst_hold;
            rdata = dir_rdata;
        end
    endtask

    task automatic wait_ack(input string nm, output int g, output logic [31:0] rd);
        g  = -1;
        rd = '0;
        for (int c = 0; c < 60 && g < 0; c++) begin
            step();
            if (ack != '0) begin
                for (int i = 0; i < NR; i++) if (ack[i]) g = i;
                rd = ack_rdata;
            end
        end
        if (g < 0) begin
            n_total++;
            n_bad++;
            $display("FAIL %s: got no ack expected ack within 60 cycles", nm);
        end
    endtask

    initial begin
        int          g;
        logic [31:0] rd;
        int          exp_order [5] = '{0, 1, 2, 3, 0};

        ARESET = 1'b1; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        ready = 1'b0; rdata = '0;
        step();
        step();
        chk("rst_busy",     64'(busy),      64'(0));
        chk("rst_ack",      64'(ack),       64'(0));
        chk("rst_transfer", 64'(transfer),  64'(0));
        chk("rst_grant",    64'(grant_idx), 64'(0));
        chk("rst_addr",     64'(addr),      64'(0));
        ARESET = 1'b0;

        // single read from requester 0
        dir_rdata = 32'hDEADBEEF;
        req[0] = 1'b1; req_write[0] = 1'b0; req_addr[0*AW +: AW] = 32'h4;
        step();
        chk("rd_transfer", 64'(transfer),  64'(1));
        chk("rd_busy",     64'(busy),      64'(1));
        chk("rd_grant",    64'(grant_idx), 64'(0));
        chk("rd_addr",     64'(addr),      64'(32'h4));
        chk("rd_write",    64'(write),     64'(0));
        step();
        chk("rd_transfer_1cyc", 64'(transfer), 64'(0));
        step();
        chk("rd_ack",       64'(ack),       64'(4'b0001));
        chk("rd_ack_rdata", 64'(ack_rdata), 64'(32'hDEADBEEF));
        req[0] = 1'b0;
        step();
        chk("rd_idle_busy",  64'(busy),      64'(0));
        chk("rd_rdata_hold", 64'(ack_rdata), 64'(32'hDEADBEEF));

        // write from requester 2, master stalls for a few cycles
        mst_hold = 1'b1;
        dir_rdata = 32'hFFFFFFFF;
        req[2] = 1'b1; req_write[2] = 1'b1;
        req_addr[2*AW +: AW] = 32'h8; req_wdata[2*DW +: DW] = 32'h12345678;
        step();
        chk("wr_transfer", 64'(transfer),  64'(1));
        chk("wr_grant",    64'(grant_idx), 64'(2));
        req_addr[2*AW +: AW] = 32'hABCD;  // ignored after grant
        step(); step(); step();
        chk("wr_addr_hold",  64'(addr),     64'(32'h8));
        chk("wr_wdata_hold", 64'(wdata),    64'(32'h12345678));
        chk("wr_write_hold", 64'(write),    64'(1));
        chk("wr_no_ack",     64'(ack),      64'(0));
        mst_hold = 1'b0;
        wait_ack("wr_ack", g, rd);
        chk("wr_ack_idx",   64'(g),  64'(2));
        chk("wr_ack_rdata", 64'(rd), 64'(0));
        req = '0; req_write = '0;
        step();

        // contention from reset: 0,1,2,3,0
        ARESET = 1'b1;
        step();
        ARESET = 1'b0;
        dir_rdata = 32'h0BADF00D;
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_ack("rr_ack", g, rd);
            chk("rr_order", 64'(g), 64'(exp_order[n]));
        end
        req = '0;
        step(); step();

        // re-request: 1 re-raised right away loses to 3
        req = 4'b1010;
        wait_ack("rereq_ack", g, rd);
        chk("rereq_first", 64'(g), 64'(1));
        wait_ack("rereq_ack", g, rd);
        chk("rereq_second", 64'(g), 64'(3));
        req[3] = 1'b0;
        wait_ack("rereq_ack", g, rd);
        chk("rereq_third", 64'(g), 64'(1));
        req = '0;
        step();

        // reset while waiting for ready
        mst_hold = 1'b1;
        req = 4'b0100;
        step(); step(); step();
        ARESET = 1'b1;
        step();
        chk("rstw_busy",      64'(busy),      64'(0));
        chk("rstw_ack",       64'(ack),       64'(0));
        chk("rstw_transfer",  64'(transfer),  64'(0));
        chk("rstw_grant",     64'(grant_idx), 64'(0));
        chk("rstw_addr",      64'(addr),      64'(0));
        chk("rstw_ack_rdata", 64'(ack_rdata), 64'(0));
        ARESET = 1'b0;
        mst_hold = 1'b0;
        req = 4'b0101;
        wait_ack("rstw_ack_after", g, rd);
        chk("rstw_first_grant", 64'(g), 64'(0));
        req = '0;
        step(); step();

        // randomized traffic, master latency and occasional resets
        mst_rand = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            step();
            ARESET = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < NR; i++) begin
                if (ack[i]) begin
                    req[i] = 1'($urandom_range(0, 1));
                    req_write[i] = 1'($urandom_range(0, 1));
                    req_addr[i*AW +: AW]  = $urandom;
                    req_wdata[i*DW +: DW] = $urandom;
                end else if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[i] = 1'b1;
                        req_write[i] = 1'($urandom_range(0, 1));
                        req_addr[i*AW +: AW]  = $urandom;
                        req_wdata[i*DW +: DW] = $urandom;
                    end
                end else if ($urandom_range(0, 49) == 0) begin
                    req[i] = 1'b0;
                end
                if ($urandom_range(0, 7) == 0) begin
                    req_addr[i*AW +: AW]  = $urandom;
                    req_wdata[i*DW +: DW] = $urandom;
                end
            end
        end
        mst_rand = 1'b0;
        ARESET = 1'b0;
        req = '0;
        for (int c = 0; c < 10; c++) step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
